// File: rtl/core_p2s_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_p2s_sched_pkg
// Description : Shared types and helpers for the parallel-to-serial scheduler.
//               Holds the scheduler state encoding and the shift-count width
//               helper used to size count ports and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package core_p2s_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4
    } p2s_sched_state_e;

    // A count must be able to represent LENGTH itself, hence LENGTH+1 codes.
    function automatic int count_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_round_robin_picker.sv
`default_nettype none
// ============================================================================
// Module      : core_round_robin_picker
// Description : Combinational round-robin search. Returns the first set bit
//               of req_i at or after ptr_i, wrapping modulo REQUESTERS.
// Ports       : req_i   - request vector
//               ptr_i   - starting position of the search (< REQUESTERS)
//               idx_o   - index of the selected requester
//               found_o - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module core_round_robin_picker #(
    parameter  int REQUESTERS = 4,
    localparam int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  found_o
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IDX_W:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest hit is the
    // last assignment and therefore wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        w_sum   = '0;
        for (int off = REQUESTERS - 1; off >= 0; off--) begin
            w_sum = {1'b0, ptr_i} + (IDX_W + 1)'(off);
            if (w_sum >= (IDX_W + 1)'(REQUESTERS)) begin
                w_sum = w_sum - (IDX_W + 1)'(REQUESTERS);
            end
            if (req_i[w_sum[IDX_W-1:0]]) begin
                idx_o   = w_sum[IDX_W-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_parallel_to_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : core_parallel_to_serial_scheduler
// Description : Round-robin scheduler sharing one external parallel-to-serial
//               shifter among REQUESTERS burst producers. Arbitrates, muxes
//               the winner's words/count to the shifter, sequences
//               load -> run -> shift -> drain and reports completion.
// Ports       : clk_i/rst_i        - clock, async active-high reset
//               req_i/req_data_i/req_count_i - per-requester request, words, count
//               grant_o/complete_o/err_o     - one-hot per-requester pulses
//               ready_i            - downstream accepts a word
//               ser_load_o/ser_run_o/ser_en_o - shifter strobes
//               ser_data_o/ser_count_o       - muxed words and count
//               ser_done_i         - shifter finished
//               valid_o/busy_o     - word valid, burst in flight
//               assert_on_i        - enables simulation checks
// Revision    : 1.0 - initial release
// ============================================================================
module core_parallel_to_serial_scheduler
    import core_p2s_sched_pkg::*;
#(
    parameter  int BITS       = 8,
    parameter  int LENGTH     = 16,
    parameter  int REQUESTERS = 4,
    localparam int CNT_W      = count_width(LENGTH),
    localparam int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [REQUESTERS-1:0]               req_i,
    input  logic [REQUESTERS*LENGTH*BITS-1:0]   req_data_i,
    input  logic [REQUESTERS*CNT_W-1:0]         req_count_i,
    output logic [REQUESTERS-1:0]               grant_o,
    output logic [REQUESTERS-1:0]               complete_o,
    output logic [REQUESTERS-1:0]               err_o,
    input  logic                                ready_i,
    output logic                                ser_load_o,
    output logic                                ser_run_o,
    output logic                                ser_en_o,
    output logic [LENGTH*BITS-1:0]              ser_data_o,
    output logic [CNT_W-1:0]                    ser_count_o,
    input  logic                                ser_done_i,
    output logic                                valid_o,
    output logic                                busy_o,
    input  logic                                assert_on_i
);

    localparam int c_BURST_W = LENGTH * BITS;

    p2s_sched_state_e r_state, w_next_state;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [IDX_W-1:0] r_rr_ptr, w_ptr_next;
    logic [CNT_W-1:0] r_sent, w_sent_next, w_sent_inc;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic [CNT_W-1:0] w_pick_count;
    logic             w_pick_ok;
    logic [1:0]       r_drain_wait;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        if (p == IDX_W'(REQUESTERS - 1)) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    core_round_robin_picker #(
        .REQUESTERS (REQUESTERS)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (r_rr_ptr),
        .idx_o   (w_pick_idx),
        .found_o (w_pick_found)
    );

    assign w_pick_count = req_count_i[int'(w_pick_idx)*CNT_W +: CNT_W];
    assign w_pick_ok    = (w_pick_count != '0) && (w_pick_count <= CNT_W'(LENGTH));

    // Select is the latched index, so it stays put from LOAD through DRAIN.
    assign ser_data_o  = req_data_i[int'(r_idx)*c_BURST_W +: c_BURST_W];
    assign ser_count_o = req_count_i[int'(r_idx)*CNT_W +: CNT_W];
    assign busy_o      = (r_state != S_IDLE);
    assign w_sent_inc  = r_sent + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_rr_ptr <= '0;
            r_sent   <= '0;
        end else begin
            r_state  <= w_next_state;
            r_idx    <= w_idx_next;
            r_rr_ptr <= w_ptr_next;
            r_sent   <= w_sent_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_idx_next   = r_idx;
        w_ptr_next   = r_rr_ptr;
        w_sent_next  = r_sent;
        grant_o      = '0;
        complete_o   = '0;
        err_o        = '0;
        ser_load_o   = 1'b0;
        ser_run_o    = 1'b0;
        ser_en_o     = 1'b0;
        valid_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The state is forced to IDLE while reset is held; gating here
                // keeps the combinational acknowledges quiet during reset too.
                if (w_pick_found && !rst_i) begin
                    if (w_pick_ok) begin
                        grant_o[w_pick_idx] = 1'b1;
                        w_idx_next          = w_pick_idx;
                        w_sent_next         = '0;
                        w_next_state        = S_LOAD;
                    end else begin
                        err_o[w_pick_idx] = 1'b1;
                        w_ptr_next        = ptr_inc(w_pick_idx);
                    end
                end
            end
            S_LOAD: begin
                ser_load_o   = 1'b1;
                w_next_state = S_START;
            end
            S_START: begin
                ser_run_o    = 1'b1;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                valid_o  = 1'b1;
                ser_en_o = ready_i;
                if (ready_i) begin
                    w_sent_next = w_sent_inc;
                    if (w_sent_inc == ser_count_o) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ser_done_i) begin
                    complete_o[r_idx] = 1'b1;
                    w_ptr_next        = ptr_inc(r_idx);
                    w_next_state      = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Cycles spent waiting in DRAIN, saturating; only feeds the check below.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drain_wait <= '0;
        end else if (r_state == S_DRAIN) begin
            if (r_drain_wait != 2'd3) begin
                r_drain_wait <= r_drain_wait + 2'd1;
            end
        end else begin
            r_drain_wait <= '0;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i && assert_on_i) begin
            a_grant_onehot:    assert ($onehot0(grant_o));
            a_complete_onehot: assert ($onehot0(complete_o));
            a_err_onehot:      assert ($onehot0(err_o));
            a_drain_timeout:   assert (!(r_state == S_DRAIN && !ser_done_i && r_drain_wait >= 2'd2));
        end
    end

endmodule
`default_nettype wire
